// File: rtl/demux_frame_collector_pkg.sv
// Shared types and widths for the demux frame collector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_frame_collector_pkg;

  localparam int SLOT_W  = 3;
  localparam int FRAME_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

endpackage

// File: rtl/demux_frame_collector_slot_counter.sv
// Slot select counter: wraps modulo 2^SLOT_W, clear has priority over increment.
// Latency: count updates on the edge where inc_i/clr_i is sampled.
// Backpressure: none; the caller gates inc_i with its accept condition.
module slot_counter
  import demux_frame_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [SLOT_W-1:0] cnt_o
);

  logic [SLOT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step with natural wrap 7 -> 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + SLOT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux_frame_collector.sv
// Collects one serial bit per demux slot 0..7 into an 8-bit frame, with a mid-frame idle abort.
// Latency: the 8th accepted bit at edge N makes frame/frame_valid visible from edge N.
// Backpressure: bit_ready drops while a completed frame waits for frame_ready.
module demux_frame_collector
  import demux_frame_collector_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic [SLOT_W-1:0]  sel,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               frame_err
);

  // A zero TIMEOUT still needs a legal (unused) counter width.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0]  TO_MAX    = CNT_W'(TIMEOUT);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               frame_valid_q, frame_valid_d;
  logic               frame_err_q, frame_err_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               sel_clr, sel_inc;
  logic               accept;

  slot_counter u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sel_clr),
    .inc_i (sel_inc),
    .cnt_o (sel)
  );

  assign bit_ready = (state_q != HOLD);
  assign accept    = bit_valid && bit_ready;

  // FSM next state, shadow capture, frame hand-off and idle timeout.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    frame_d       = frame_q;
    frame_valid_d = frame_valid_q;
    frame_err_d   = 1'b0;
    idle_cnt_d    = idle_cnt_q;
    sel_clr       = 1'b0;
    sel_inc       = 1'b0;
    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (accept) begin
          shadow_d[sel] = bit_in;
          sel_inc       = 1'b1;
          state_d       = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          idle_cnt_d = '0;
          sel_inc    = 1'b1;
          if (sel == LAST_SLOT) begin
            // Slot 7 bit goes straight into the frame; the counter wraps to 0.
            frame_d       = {bit_in, shadow_q[FRAME_W-2:0]};
            frame_valid_d = 1'b1;
            shadow_d      = '0;
            state_d       = HOLD;
          end else begin
            shadow_d[sel] = bit_in;
          end
        end else if (TIMEOUT != 0) begin
          if (idle_cnt_q == TO_LAST) begin
            // Abort the partial frame; the last completed frame stays on the outputs.
            frame_err_d = 1'b1;
            shadow_d    = '0;
            sel_clr     = 1'b1;
            idle_cnt_d  = '0;
            state_d     = IDLE;
          end else if (idle_cnt_q != TO_MAX) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (frame_valid_q && frame_ready) begin
          frame_valid_d = 1'b0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_demux_frame_collector.sv
// Self-checking bench for demux_frame_collector with a transaction-level reference model.
// Latency: checks outputs once per cycle, at the falling edge after each rising edge.
// Backpressure: exercises frame_ready held low, toggled and random.
module tb_demux_frame_collector;

  localparam int TO = 4;

  logic       clk;
  logic       rst_n;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_ready;
  logic [2:0] sel;
  logic [7:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       frame_err;

  demux_frame_collector #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .bit_ready   (bit_ready),
    .sel         (sel),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: bits gathered so far, idle cycles since last bit, held frame.
  bit       m_bits[$];
  int       m_idle;
  bit [7:0] m_frame;
  bit       m_holding;
  bit       m_err;
  int       cyc;
  int       fv_rise[$];
  bit       fv_prev;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_idle    = 0;
    m_frame   = 8'h00;
    m_holding = 1'b0;
    m_err     = 1'b0;
  endtask

  task automatic check_outputs();
    chk("sel", {5'b0, sel}, 8'(m_bits.size()));
    chk("frame", frame, m_frame);
    chk("frame_valid", {7'b0, frame_valid}, {7'b0, m_holding});
    chk("frame_err", {7'b0, frame_err}, {7'b0, m_err});
  endtask

  // One clock cycle: drive at the falling edge, check ready, advance the model, check outputs.
  task automatic cycle(input bit bv, input bit bi, input bit fr);
    bit acc;
    bit [7:0] f;
    bit_valid   = bv;
    bit_in      = bi;
    frame_ready = fr;
    #1;
    chk("bit_ready", {7'b0, bit_ready}, {7'b0, !m_holding});
    acc   = bv && !m_holding;
    m_err = 1'b0;
    if (m_holding) begin
      if (fr) m_holding = 1'b0;
    end else if (acc) begin
      m_bits.push_back(bi);
      m_idle = 0;
      if (m_bits.size() == 8) begin
        f = 8'h00;
        for (int k = 0; k < 8; k++) f[k] = m_bits[k];
        m_frame   = f;
        m_holding = 1'b1;
        m_bits.delete();
      end
    end else if (m_bits.size() > 0) begin
      m_idle++;
      if (TO > 0 && m_idle == TO) begin
        m_err = 1'b1;
        m_bits.delete();
        m_idle = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (frame_valid && !fv_prev) fv_rise.push_back(cyc);
    fv_prev = frame_valid;
    check_outputs();
  endtask

  task automatic send_byte(input bit [7:0] b, input bit fr);
    for (int k = 0; k < 8; k++) cycle(1'b1, b[k], fr);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
    check_outputs();
    chk("reset_bit_ready", {7'b0, bit_ready}, 8'h01);
  endtask

  initial begin
    bit [7:0] tv;
    rst_n       = 1'b1;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    frame_ready = 1'b0;
    cyc         = 0;
    fv_prev     = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("por_sel", {5'b0, sel}, 8'h00);
    chk("por_frame", frame, 8'h00);
    apply_reset();

    // Frame 1,0,1,1,0,0,1,0 with consumer always ready.
    tv = 8'b0100_1101;
    send_byte(tv, 1'b1);
    chk("frame_4d", frame, 8'h4D);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);

    // Same frame, consumer stalls 5 cycles while bits are offered.
    send_byte(tv, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    chk("hold_release_sel", {5'b0, sel}, 8'h00);
    cycle(1'b0, 1'b0, 1'b0);

    // Three bits then silence: abort after TO idle edges, frame kept.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < TO + 2; i++) cycle(1'b0, 1'b0, 1'b0);
    chk("abort_keeps_frame", frame, 8'h4D);

    // Valid toggling every cycle: idle gaps of one never abort.
    for (int i = 0; i < 16; i++) cycle(1'(i % 2 == 0), 1'($urandom_range(0, 1)), 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a frame (sel = 5).
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
    chk("pre_reset_sel", {5'b0, sel}, 8'h05);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h5A, 1'b1);
    chk("post_reset_frame", frame, 8'h5A);
    cycle(1'b0, 1'b0, 1'b1);

    // Back-to-back frames A5 then 3C: valid pulses 9 cycles apart.
    fv_rise.delete();
    send_byte(8'hA5, 1'b1);
    chk("b2b_first", frame, 8'hA5);
    cycle(1'b0, 1'b0, 1'b1);
    send_byte(8'h3C, 1'b1);
    chk("b2b_second", frame, 8'h3C);
    cycle(1'b0, 1'b0, 1'b1);
    chk("b2b_pulses", 8'(fv_rise.size()), 8'h02);
    if (fv_rise.size() == 2) chk("b2b_period", 8'(fv_rise[1] - fv_rise[0]), 8'd9);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) != 0));
      if (i % 50 == 49) begin
        cycle(1'b0, 1'b0, 1'b1);
        for (int j = 0; j < TO; j++) cycle(1'b0, 1'b0, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_frame_collector.md
# demux_frame_collector

Serial-to-parallel frame collector that sits directly downstream of the 1-to-8 demultiplexer stage. It steps a 3-bit slot select through channels 0..7 and captures one input bit per slot into an 8-bit frame. It hands each completed frame to the consumer with a valid/ready handshake. A mid-frame inactivity timeout aborts partial frames.

## Interface
Parameters:
- TIMEOUT, default 16: idle cycles allowed between accepted bits inside a frame before abort; 0 disables the timeout.

Ports:
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- bit_in  in  1  serial data bit for the current slot
- bit_valid  in  1  bit_in is valid this cycle
- bit_ready  out  1  block accepts a bit this cycle
- sel  out  3  current slot index; sel[2]=s1 (MSB), sel[1]=s2, sel[0]=s3 (LSB), matching the demux select order
- frame  out  8  last completed frame; frame[k] = bit captured in slot k (demux output o(k+1))
- frame_valid  out  1  frame holds an unconsumed completed frame
- frame_ready  in  1  consumer takes the frame
- frame_err  out  1  one-cycle pulse on timeout abort

## Operation
- States: IDLE, COLLECT, HOLD.
- Accept condition: bit_valid && bit_ready.
  - On accept, shadow[sel] <= bit_in and sel <= sel+1 (mod 8).
  - bit_ready = 1 in IDLE and COLLECT; 0 in HOLD.
- IDLE: sel = 0. An accept moves to COLLECT with sel = 1.
- COLLECT:
  - Accepting with sel = 7 completes the frame: frame <= shadow with bit 7 = bit_in, frame_valid <= 1, sel wraps to 0, next state HOLD.
  - Otherwise the state stays COLLECT.
- HOLD:
  - frame and frame_valid are held stable until frame_valid && frame_ready.
  - On that handshake edge: frame_valid <= 0, next state IDLE.
  - A bit offered during HOLD is not accepted. It is taken in the next cycle at the earliest.
- Timeout (TIMEOUT > 0, COLLECT only):
  - idle_cnt increments each cycle with no accept and clears on accept.
  - When idle_cnt reaches TIMEOUT: frame_err pulses for 1 cycle, shadow clears to 0, sel <= 0, next state IDLE.
  - frame and frame_valid are unchanged by an abort.
- The idle counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.
- frame changes only on frame completion. The shadow register is never visible on the outputs.
- Reset (asserted at any time, including mid-frame or in HOLD): state IDLE, sel = 0, shadow = 0, frame = 8'h00, frame_valid = 0, frame_err = 0, idle_cnt = 0, bit_ready = 1 after release.

## Timing
- Each accepted bit takes one cycle. sel updates on the accepting edge.
- Latency: the 8th bit accepted at edge N gives frame and frame_valid = 1 from edge N (visible in cycle N+1).
- Back-to-back frames: the minimum period is 9 cycles (8 accepts plus 1 HOLD cycle with frame_ready held high).
- Timeout: with TIMEOUT = T and the last accept at edge N, frame_err = 1 in the cycle after edge N+T. It deasserts at the following edge.
- frame_ready is ignored when frame_valid = 0.
- All outputs are registered except bit_ready, which is decoded from the state.

## Structure
- Shared package entries:
  - state enum {IDLE, COLLECT, HOLD}
  - SLOT_W = 3
  - FRAME_W = 8
- The natural sub-module is `slot_counter`: a 3-bit wrap counter with clear and increment-enable that drives sel. The remaining FSM, shadow register, and timeout logic stay in the top level.

## Test plan
- Reset, then serial bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles with frame_ready = 1 -> sel steps 0..7 then back to 0; frame = 8'b01001101 with frame_valid for 1 cycle; no frame_err.
- Same bits with frame_ready = 0 for 5 cycles -> frame_valid and frame stay stable, bit_ready = 0, the bit offered in HOLD is not captured; release -> IDLE on the next edge.
- TIMEOUT = 4, 3 bits accepted then bit_valid = 0 -> frame_err pulse 1 cycle after the 4th idle edge; sel = 0; the previous frame is unchanged.
- bit_valid toggling 1/0 every cycle for 16 cycles, TIMEOUT = 4 -> frame completes after the 15th cycle with no error.
- rst_n asserted asynchronously with sel = 5 in COLLECT -> all outputs go to reset values immediately; the next frame starts at slot 0.
- Two frames 8'hA5 then 8'h3C back-to-back with frame_ready = 1 -> two frame_valid pulses 9 cycles apart with correct values.
